asynchronous_fifo_write_packer: RTL

//   Write-side front end of the asynchronous advanced FIFO, in the write_clock domain.
//   - Upstream: narrow valid/ready stream.
//   - Packing: gathers RATIO beats into one wide word. Beat 0 sits in the LSBs.
//   - Downstream: drives the FIFO write_enable/write_data pair.
//   - Short packets: in_last closes a partial word early. A beat-count and last tag travel with each word.
//   - One holding register decouples packing from write_full back-pressure.

---
 rtl/asynchronous_fifo_write_packer_if.sv | 27 ++
 rtl/asynchronous_fifo_write_packer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/asynchronous_fifo_write_packer_if.sv
// Upstream beat stream plus FIFO write port of the write-side packer.
// The packer uses the slave view; the environment drives the master view.
interface asynchronous_fifo_write_packer_if #(
    parameter int INPUT_WIDTH = 8,
    parameter int RATIO       = 4
);
    localparam int RATIO_LOG2 = $clog2(RATIO);
    localparam int FIFO_WIDTH = 1 + RATIO_LOG2 + RATIO * INPUT_WIDTH;

    logic                   in_valid;
    logic                   in_ready;
    logic [INPUT_WIDTH-1:0] in_data;
    logic                   in_last;
    logic                   fifo_write_enable;
    logic [FIFO_WIDTH-1:0]  fifo_write_data;
    logic                   fifo_write_full;

    modport slave (
        input  in_valid, in_data, in_last, fifo_write_full,
        output in_ready, fifo_write_enable, fifo_write_data
    );

    modport master (
        output in_valid, in_data, in_last, fifo_write_full,
        input  in_ready, fifo_write_enable, fifo_write_data
    );
endinterface

// File: rtl/asynchronous_fifo_write_packer.sv
// Write-domain packer: gathers RATIO narrow beats into one FIFO word {last, beats-1, lanes}
// behind a single holding register that absorbs write_full back-pressure.
module asynchronous_fifo_write_packer_lane #(
    parameter int W    = 8,
    parameter int IDXW = 2,
    parameter int LANE = 0
) (
    input  logic            write_clock,
    input  logic            write_resetn,
    input  logic            clr_i,
    input  logic            accept_i,
    input  logic [IDXW-1:0] idx_i,
    input  logic [W-1:0]    data_i,
    output logic [W-1:0]    merged_o
);
    localparam logic [IDXW-1:0] MY_IDX = IDXW'(LANE);

    logic [W-1:0] lane_q;

    always_ff @(posedge write_clock or negedge write_resetn) begin
        if (!write_resetn)                       lane_q <= '0;
        else if (clr_i)                          lane_q <= '0;
        else if (accept_i && (idx_i == MY_IDX))  lane_q <= data_i;
    end

    // Closing beat is merged straight in; lanes above the closing index read as zero.
    always_comb begin
        merged_o = '0;
        if (idx_i == MY_IDX)     merged_o = data_i;
        else if (idx_i > MY_IDX) merged_o = lane_q;
    end
endmodule

module asynchronous_fifo_write_packer #(
    parameter int INPUT_WIDTH = 8,
    parameter int RATIO       = 4,
    parameter int RATIO_LOG2  = $clog2(RATIO),
    parameter int FIFO_WIDTH  = 1 + RATIO_LOG2 + RATIO * INPUT_WIDTH
) (
    input  logic                                  write_clock,
    input  logic                                  write_resetn,
    input  logic                                  write_flush,
    asynchronous_fifo_write_packer_if.slave       bus,
    output logic                                  packer_busy,
    output logic [7:0]                            dropped_beats
);
    localparam logic [RATIO_LOG2-1:0] LAST_IDX = RATIO_LOG2'(RATIO - 1);
    localparam int SUMW = 16;

    logic [RATIO_LOG2-1:0]                 idx_q, idx_d;
    logic [FIFO_WIDTH-1:0]                 hold_q, hold_d;
    logic                                  hold_vld_q, hold_vld_d;
    logic [7:0]                            dropped_q, dropped_d;
    logic [RATIO-1:0][INPUT_WIDTH-1:0]     merged;
    logic                                  drain, ready, accept, close, lane_clr;
    logic [RATIO_LOG2-1:0]                 held_cnt;
    logic [SUMW-1:0]                       drop_sum;

    assign drain    = hold_vld_q && !bus.fifo_write_full && !write_flush;
    assign ready    = !write_flush && (!hold_vld_q || drain);
    assign accept   = bus.in_valid && ready;
    assign close    = accept && ((idx_q == LAST_IDX) || bus.in_last);
    assign lane_clr = write_flush || close;
    assign held_cnt = hold_q[FIFO_WIDTH-2 -: RATIO_LOG2];
    assign drop_sum = SUMW'(dropped_q) + SUMW'(idx_q)
                    + (hold_vld_q ? (SUMW'(held_cnt) + SUMW'(1)) : SUMW'(0));

    for (genvar g = 0; g < RATIO; g++) begin : g_lane
        asynchronous_fifo_write_packer_lane #(
            .W(INPUT_WIDTH), .IDXW(RATIO_LOG2), .LANE(g)
        ) u_lane (
            .write_clock  (write_clock),
            .write_resetn (write_resetn),
            .clr_i        (lane_clr),
            .accept_i     (accept),
            .idx_i        (idx_q),
            .data_i       (bus.in_data),
            .merged_o     (merged[g])
        );
    end

    always_comb begin
        idx_d      = idx_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        dropped_d  = dropped_q;
        if (write_flush) begin
            idx_d      = '0;
            hold_d     = '0;
            hold_vld_d = 1'b0;
            dropped_d  = (drop_sum > SUMW'(255)) ? 8'hFF : drop_sum[7:0];
        end else begin
            if (drain) begin
                hold_d     = '0;
                hold_vld_d = 1'b0;
            end
            // A closing word overrides the drain so back-to-back words see no bubble.
            if (close) begin
                hold_d     = {bus.in_last, idx_q, merged};
                hold_vld_d = 1'b1;
                idx_d      = '0;
            end else if (accept) begin
                idx_d = idx_q + RATIO_LOG2'(1);
            end
        end
    end

    always_ff @(posedge write_clock or negedge write_resetn) begin
        if (!write_resetn) begin
            idx_q      <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            dropped_q  <= '0;
        end else begin
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            dropped_q  <= dropped_d;
        end
    end

    assign bus.in_ready          = ready;
    assign bus.fifo_write_enable = drain;
    assign bus.fifo_write_data   = hold_vld_q ? hold_q : '0;
    assign packer_busy           = (idx_q != '0) || hold_vld_q;
    assign dropped_beats         = dropped_q;
endmodule
